// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of a square wave on tone_in and
// classifies it as one of ten note digits, reporting silence otherwise.
module tone_decoder #(
  parameter int unsigned CLK_HALF = 25_000_000,
  parameter int unsigned TOL      = 64,
  parameter int unsigned STABLE   = 3,
  parameter int unsigned TIMEOUT  = 200_000,
  parameter int unsigned CNT_W    = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [3:0]       note_code,
  output logic             note_valid,
  output logic             new_note,
  output logic [CNT_W-1:0] period
);

  localparam int unsigned NOTES     = 10;
  localparam logic [3:0]  UNMATCHED = 4'd10;
  localparam int unsigned MC_W      = (STABLE < 2) ? 1 : $clog2(STABLE + 1);

  typedef enum logic {SILENT, TRACK} state_t;

  state_t            state;
  logic              sync1, sync2, prev, edge_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  p_meas;
  logic [MC_W-1:0]   match_cnt;
  logic [MC_W-1:0]   mc_upd;
  logic [3:0]        last_cand;
  logic [3:0]        cand;
  logic [CNT_W:0]    diff;
  logic [CNT_W:0]    mag;

  // Expected full period in clk cycles for a note digit.
  function automatic logic [CNT_W-1:0] exp_of(input int unsigned d);
    int unsigned f;
    case (d)
      0:       f = 659;
      1:       f = 262;
      2:       f = 294;
      3:       f = 330;
      4:       f = 349;
      5:       f = 392;
      6:       f = 440;
      7:       f = 494;
      8:       f = 524;
      9:       f = 587;
      default: f = 659;
    endcase
    return CNT_W'(2 * (CLK_HALF / f));
  endfunction

  assign p_meas = cnt + CNT_W'(1);

  // Two-flop synchronizer, previous-sample register and registered edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= tone_in;
      sync2  <= sync1;
      prev   <= sync2;
      edge_q <= sync2 & ~prev;
    end
  end

  // Classify the measured period against the note table (signed, one bit wider).
  always_comb begin
    cand = UNMATCHED;
    diff = '0;
    mag  = '0;
    for (int unsigned i = 0; i < NOTES; i++) begin
      diff = {1'b0, p_meas} - {1'b0, exp_of(i)};
      mag  = diff[CNT_W] ? (~diff + (CNT_W+1)'(1)) : diff;
      if (mag <= (CNT_W+1)'(TOL)) cand = 4'(i);
    end
  end

  // Match count after this edge: restart on a new candidate, saturate at STABLE.
  always_comb begin
    if (cand != last_cand)
      mc_upd = MC_W'(1);
    else if (match_cnt == MC_W'(STABLE))
      mc_upd = match_cnt;
    else
      mc_upd = match_cnt + MC_W'(1);
  end

  // Period counter, tracking FSM and registered note outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SILENT;
      cnt        <= '0;
      match_cnt  <= '0;
      last_cand  <= UNMATCHED;
      note_code  <= UNMATCHED;
      note_valid <= 1'b0;
      new_note   <= 1'b0;
      period     <= '0;
    end else begin
      new_note <= 1'b0;
      if (edge_q)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CNT_W'(1);

      case (state)
        SILENT: begin
          // First edge is only a timing reference.
          if (edge_q) state <= TRACK;
        end
        TRACK: begin
          if (edge_q) begin
            period    <= p_meas;
            match_cnt <= mc_upd;
            last_cand <= cand;
            if (cand == UNMATCHED) begin
              note_code  <= UNMATCHED;
              note_valid <= 1'b0;
            end else if (mc_upd >= MC_W'(STABLE)) begin
              note_code  <= cand;
              note_valid <= 1'b1;
              new_note   <= !note_valid || (note_code != cand);
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state      <= SILENT;
            note_code  <= UNMATCHED;
            note_valid <= 1'b0;
            match_cnt  <= '0;
            last_cand  <= UNMATCHED;
          end
        end
        default: state <= SILENT;
      endcase
    end
  end

endmodule
